// File: rtl/bless_port_alloc_if.sv
// Flit-side bus of the deflection port allocator: four input slots, four
// stamped output slots, crossbar selects and the golden node ID.
`ifndef DATA_WIDTH_XBAR
`define DATA_WIDTH_XBAR 32
`endif
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 4
`endif
`ifndef NULL_PC
`define NULL_PC 3'd7
`endif
// Field positions are LSB indices; widths come from NUM_PORT-1, AGE_W, SRC_W.
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef PPV_POS
`define PPV_POS 27
`endif
`ifndef NL_PPV_POS
`define NL_PPV_POS 23
`endif
`ifndef AGE_POS
`define AGE_POS 15
`endif
`ifndef SRC_POS
`define SRC_POS 11
`endif

interface bless_port_alloc_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH_XBAR,
    parameter int SRC_W      = 4,
    parameter int RANK_W     = `PC_INDEX_WIDTH - 1
);
    logic [DATA_WIDTH-1:0] in_0, in_1, in_2, in_3;
    logic [DATA_WIDTH-1:0] out_0, out_1, out_2, out_3;
    logic [RANK_W-1:0]     indir_rank0, indir_rank1, indir_rank2, indir_rank3;
    logic [SRC_W-1:0]      golden_id;

    modport master (
        output in_0, in_1, in_2, in_3,
        input  out_0, out_1, out_2, out_3,
        input  indir_rank0, indir_rank1, indir_rank2, indir_rank3,
        input  golden_id
    );

    modport slave (
        input  in_0, in_1, in_2, in_3,
        output out_0, out_1, out_2, out_3,
        output indir_rank0, indir_rank1, indir_rank2, indir_rank3,
        output golden_id
    );
endinterface

// File: rtl/bless_port_alloc.sv
// Registered deflection port allocator: ranks four flits, grants one output
// port each, stamps grant and age. Golden-packet priority under GOLDEN_PKT_EN.
`ifndef DATA_WIDTH_XBAR
`define DATA_WIDTH_XBAR 32
`endif
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 4
`endif
`ifndef NULL_PC
`define NULL_PC 3'd7
`endif
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef PPV_POS
`define PPV_POS 27
`endif
`ifndef NL_PPV_POS
`define NL_PPV_POS 23
`endif
`ifndef AGE_POS
`define AGE_POS 15
`endif
`ifndef SRC_POS
`define SRC_POS 11
`endif

module bless_port_alloc #(
    parameter int DATA_WIDTH = `DATA_WIDTH_XBAR,
    parameter int AGE_W      = 8,
    parameter int SRC_W      = 4,
    parameter int NUM_NODES  = 16,
    parameter int EPOCH_LEN  = 64
) (
    input  logic              clk,
    input  logic              reset,
    bless_port_alloc_if.slave bus
);
    localparam int NP     = `NUM_PORT - 1;
    localparam int RANK_W = `PC_INDEX_WIDTH - 1;
    localparam int KEY_W  = AGE_W + 2;

    logic [DATA_WIDTH-1:0] in_a   [4];
    logic [DATA_WIDTH-1:0] out_d  [4];
    logic [DATA_WIDTH-1:0] out_q  [4];
    logic [RANK_W-1:0]     rank_d [4];
    logic [RANK_W-1:0]     rank_q [4];
    logic [3:0]            valid;
    logic [NP-1:0]         ppv    [4];
    logic [AGE_W-1:0]      age    [4];
    logic [3:0]            golden;
    logic [KEY_W-1:0]      key    [4];
    logic [1:0]            rank_pos [4];
    logic [NP-1:0]         grant  [4];
    logic [NP-1:0]         free;
    logic [NP-1:0]         cand;
    logic [SRC_W-1:0]      golden_id_w;

    assign in_a[0] = bus.in_0;
    assign in_a[1] = bus.in_1;
    assign in_a[2] = bus.in_2;
    assign in_a[3] = bus.in_3;

`ifdef GOLDEN_PKT_EN
    localparam int EP_W = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;

    logic [EP_W-1:0]  epoch_d, epoch_q;
    logic [SRC_W-1:0] golden_id_d, golden_id_q;

    always_comb begin
        epoch_d     = epoch_q + EP_W'(1);
        golden_id_d = golden_id_q;
        if (epoch_q == EP_W'(EPOCH_LEN - 1)) begin
            epoch_d     = '0;
            golden_id_d = (golden_id_q == SRC_W'(NUM_NODES - 1)) ? '0 : golden_id_q + SRC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            epoch_q     <= '0;
            golden_id_q <= '0;
        end else begin
            epoch_q     <= epoch_d;
            golden_id_q <= golden_id_d;
        end
    end

    assign golden_id_w = golden_id_q;
`else
    assign golden_id_w = '0;
`endif

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            valid[k] = in_a[k][`VALID_POS];
            ppv[k]   = in_a[k][`PPV_POS +: NP];
            age[k]   = in_a[k][`AGE_POS +: AGE_W];
`ifdef GOLDEN_PKT_EN
            golden[k] = (in_a[k][`SRC_POS +: SRC_W] == golden_id_w);
`else
            golden[k] = 1'b0;
`endif
            // Valid as the top key bit pushes invalid slots to the back.
            key[k] = {valid[k], golden[k], age[k]};
        end
    end

    // All-pairs comparison: each loss pushes a slot one rank position back.
    always_comb begin
        for (int k = 0; k < 4; k++) rank_pos[k] = 2'd0;
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (key[i] >= key[j]) rank_pos[j] = rank_pos[j] + 2'd1;
                else                  rank_pos[i] = rank_pos[i] + 2'd1;
            end
        end
    end

    always_comb begin
        free = '1;
        cand = '0;
        for (int k = 0; k < 4; k++) grant[k] = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (valid[k] && rank_pos[k] == 2'(r)) begin
                    cand = ppv[k] & free;
                    if (cand == '0) cand = free;
                    grant[k] = cand & (~cand + NP'(1));
                    free     = free & ~grant[k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            out_d[k]  = in_a[k];
            rank_d[k] = `NULL_PC;
            out_d[k][`NL_PPV_POS +: NP] = '0;
            if (valid[k]) begin
                out_d[k][`NL_PPV_POS +: NP] = grant[k];
                out_d[k][`AGE_POS +: AGE_W] = (age[k] == '1) ? age[k] : age[k] + AGE_W'(1);
                rank_d[k] = RANK_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                out_q[k]  <= '0;
                rank_q[k] <= `NULL_PC;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                out_q[k]  <= out_d[k];
                rank_q[k] <= rank_d[k];
            end
        end
    end

    assign bus.out_0       = out_q[0];
    assign bus.out_1       = out_q[1];
    assign bus.out_2       = out_q[2];
    assign bus.out_3       = out_q[3];
    assign bus.indir_rank0 = rank_q[0];
    assign bus.indir_rank1 = rank_q[1];
    assign bus.indir_rank2 = rank_q[2];
    assign bus.indir_rank3 = rank_q[3];
    assign bus.golden_id   = golden_id_w;
endmodule

// File: tb/tb_bless_port_alloc.sv
// Bench for bless_port_alloc: directed cases plus random traffic against a
// sort-and-assign reference model. Follows GOLDEN_PKT_EN like the design.
`ifndef DATA_WIDTH_XBAR
`define DATA_WIDTH_XBAR 32
`endif
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 4
`endif
`ifndef NULL_PC
`define NULL_PC 3'd7
`endif
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef PPV_POS
`define PPV_POS 27
`endif
`ifndef NL_PPV_POS
`define NL_PPV_POS 23
`endif
`ifndef AGE_POS
`define AGE_POS 15
`endif
`ifndef SRC_POS
`define SRC_POS 11
`endif

module tb_bless_port_alloc;
    localparam int DW    = 32;
    localparam int AGE_W = 8;
    localparam int SRC_W = 4;
    localparam int NODES = 16;
    localparam int EPOCH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bless_port_alloc_if #(.DATA_WIDTH(DW), .SRC_W(SRC_W)) bus ();

    bless_port_alloc #(
        .DATA_WIDTH(DW), .AGE_W(AGE_W), .SRC_W(SRC_W),
        .NUM_NODES(NODES), .EPOCH_LEN(EPOCH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    logic [DW-1:0] cur      [4];
    logic [DW-1:0] exp_out  [4];
    logic [2:0]    exp_rank [4];
    logic [DW-1:0] obs_out  [4];
    logic [2:0]    obs_rank [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input bit v, input logic [3:0] ppv,
                                         input logic [7:0] age, input logic [3:0] src);
        logic [DW-1:0] f;
        f = DW'($urandom);
        f[`VALID_POS]          = v;
        f[`PPV_POS +: 4]       = ppv;
        f[`AGE_POS +: AGE_W]   = age;
        f[`SRC_POS +: SRC_W]   = src;
        return f;
    endfunction

    function automatic logic [3:0] nl(input logic [DW-1:0] f);
        return f[`NL_PPV_POS +: 4];
    endfunction

    // Reference: sort valid flits by (golden, age) descending, stable on index,
    // then hand out ports in that order from a free set.
    task automatic model_eval(input bit rst, input int gid);
        int   order[$];
        bit   used[4];
        int   best, bestkey, key;
        logic [3:0] free, c, g;
        for (int k = 0; k < 4; k++) begin
            exp_out[k]  = '0;
            exp_rank[k] = `NULL_PC;
            used[k]     = 0;
        end
        if (rst) return;
        for (int r = 0; r < 4; r++) begin
            best = -1; bestkey = -1;
            for (int k = 0; k < 4; k++) begin
                if (cur[k][`VALID_POS] && !used[k]) begin
                    key = int'(cur[k][`AGE_POS +: AGE_W]);
`ifdef GOLDEN_PKT_EN
                    if (int'(cur[k][`SRC_POS +: SRC_W]) == gid) key += 1000;
`endif
                    if (key > bestkey) begin best = k; bestkey = key; end
                end
            end
            if (best >= 0) begin used[best] = 1; order.push_back(best); end
        end
        free = 4'hf;
        for (int k = 0; k < 4; k++) begin
            exp_out[k] = cur[k];
            exp_out[k][`NL_PPV_POS +: 4] = 4'h0;
        end
        foreach (order[i]) begin
            int k;
            k = order[i];
            c = cur[k][`PPV_POS +: 4] & free;
            if (c == 0) c = free;
            g = 0;
            for (int b = 3; b >= 0; b--) if (c[b]) g = 4'(1 << b);
            free &= ~g;
            exp_out[k][`NL_PPV_POS +: 4] = g;
            key = int'(cur[k][`AGE_POS +: AGE_W]);
            exp_out[k][`AGE_POS +: AGE_W] = (key == 255) ? 8'd255 : 8'(key + 1);
            exp_rank[k] = 3'(k);
        end
    endtask

    task automatic step(input bit rst);
        int gid_in, gid_exp;
`ifdef GOLDEN_PKT_EN
        gid_in = (n_cyc / EPOCH) % NODES;
`else
        gid_in = 0;
`endif
        reset    = rst;
        bus.in_0 = cur[0];
        bus.in_1 = cur[1];
        bus.in_2 = cur[2];
        bus.in_3 = cur[3];
        model_eval(rst, gid_in);
        @(posedge clk);
        #1;
        if (rst) n_cyc = 0; else n_cyc++;
`ifdef GOLDEN_PKT_EN
        gid_exp = (n_cyc / EPOCH) % NODES;
`else
        gid_exp = 0;
`endif
        obs_out[0] = bus.out_0; obs_out[1] = bus.out_1;
        obs_out[2] = bus.out_2; obs_out[3] = bus.out_3;
        obs_rank[0] = bus.indir_rank0; obs_rank[1] = bus.indir_rank1;
        obs_rank[2] = bus.indir_rank2; obs_rank[3] = bus.indir_rank3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out%0d", k), 64'(obs_out[k]), 64'(exp_out[k]));
            chk($sformatf("rank%0d", k), 64'(obs_rank[k]), 64'(exp_rank[k]));
        end
        chk("golden_id", 64'(bus.golden_id), 64'(gid_exp));
    endtask

    task automatic rand_set();
        for (int k = 0; k < 4; k++) begin
            int sel;
            logic [7:0] a;
            sel = $urandom_range(0, 3);
            a = (sel == 0) ? 8'd255 : (sel == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            cur[k] = mk($urandom_range(0, 3) != 0, 4'($urandom), a, 4'($urandom));
        end
    endtask

    initial begin
        rand_set();
        step(1'b1);
        for (int i = 0; i < 3; i++) begin
            rand_set();
            step(1'b1);
            chk("rst_out0", 64'(bus.out_0), 64'd0);
        end

        // Age ordering with all flits fighting for port 0.
        cur[0] = mk(1, 4'b0001, 8'd5, 4'd10);
        cur[1] = mk(1, 4'b0001, 8'd9, 4'd10);
        cur[2] = mk(1, 4'b0001, 8'd2, 4'd10);
        cur[3] = mk(1, 4'b0001, 8'd7, 4'd10);
`ifdef GOLDEN_PKT_EN
        for (int k = 0; k < 4; k++) cur[k][`SRC_POS +: SRC_W] = 4'd12;
`endif
        step(1'b0);
        chk("age_nl1", 64'(nl(bus.out_1)), 64'b0001);
        chk("age_nl3", 64'(nl(bus.out_3)), 64'b0010);
        chk("age_nl0", 64'(nl(bus.out_0)), 64'b0100);
        chk("age_nl2", 64'(nl(bus.out_2)), 64'b1000);
        chk("age_inc1", 64'(bus.out_1[`AGE_POS +: AGE_W]), 64'd10);

        // Distinct productive ports, no deflection.
        cur[0] = mk(1, 4'b0010, 8'd4, 4'd13);
        cur[1] = mk(1, 4'b0001, 8'd4, 4'd13);
        cur[2] = mk(1, 4'b1000, 8'd4, 4'd13);
        cur[3] = mk(1, 4'b0100, 8'd4, 4'd13);
        step(1'b0);
        chk("prod_nl0", 64'(nl(bus.out_0)), 64'b0010);
        chk("prod_nl2", 64'(nl(bus.out_2)), 64'b1000);

        // Golden epoch: reset, 4 idle cycles, then golden src=1 vs old flit.
        for (int k = 0; k < 4; k++) cur[k] = mk(0, 4'h0, 8'd0, 4'd0);
        step(1'b1);
        for (int i = 0; i < 4; i++) step(1'b0);
        cur[0] = mk(1, 4'b0100, 8'd200, 4'd3);
        cur[2] = mk(1, 4'b0100, 8'd0,   4'd1);
        step(1'b0);
`ifdef GOLDEN_PKT_EN
        chk("gold_nl2", 64'(nl(bus.out_2)), 64'b0100);
        chk("gold_nl0", 64'(nl(bus.out_0)), 64'b0001);
`else
        chk("gold_nl0", 64'(nl(bus.out_0)), 64'b0100);
        chk("gold_nl2", 64'(nl(bus.out_2)), 64'b0001);
`endif

        // Saturation.
        cur[0] = mk(0, 4'h3, 8'd40, 4'd0);
        cur[1] = mk(1, 4'h1, 8'd255, 4'd0);
        cur[2] = mk(0, 4'h2, 8'd41, 4'd0);
        cur[3] = mk(1, 4'h1, 8'd3, 4'd0);
        step(1'b0);
        chk("sat_age1", 64'(bus.out_1[`AGE_POS +: AGE_W]), 64'd255);
        chk("sat_age3", 64'(bus.out_3[`AGE_POS +: AGE_W]), 64'd4);

        // Invalid slot 2 and disjoint grants, then a 1-cycle reset.
        rand_set();
        for (int k = 0; k < 4; k++) cur[k][`VALID_POS] = (k != 2);
        step(1'b0);
        chk("inv_nl2", 64'(nl(bus.out_2)), 64'd0);
        chk("inv_rank2", 64'(bus.indir_rank2), 64'(`NULL_PC));
        chk("disjoint", 64'((nl(bus.out_0) & nl(bus.out_1)) | (nl(bus.out_0) & nl(bus.out_3))
                            | (nl(bus.out_1) & nl(bus.out_3))), 64'd0);
        chk("granted", 64'($countones(nl(bus.out_0) | nl(bus.out_1) | nl(bus.out_3))), 64'd3);
        rand_set();
        step(1'b1);
        rand_set();
        step(1'b0);

        for (int i = 0; i < 300; i++) begin
            rand_set();
            step(i == 150);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
